// File: rtl/adc_axil_regfile_write.sv
// AXI4-Lite write-only register file for ADC capture control.
// Independent AW/W holding buffers, byte-lane merge, SLVERR on out-of-range writes, self-clearing bits.
//
// state | meaning
// IDLE  | collecting AW and W into their holding buffers
// WRITE | one cycle: decode, merge byte lanes, latch response
// RESP  | BVALID held until BREADY
module adc_axil_regfile_write #(
  parameter int                     NUM_REGS    = 8,
  parameter int                     ADDR_WIDTH  = 8,
  parameter logic [NUM_REGS*32-1:0] RESET_VALUE = '0,
  parameter logic [NUM_REGS*32-1:0] PULSE_MASK  = '0
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [ADDR_WIDTH-1:0]    AWADDR,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [31:0]              WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic [NUM_REGS*32-1:0]   regs_out,
  output logic [NUM_REGS-1:0]      wr_strobe
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]              state_q, state_d;
  logic                    aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-3:0]   aw_addr_q, aw_addr_d;
  logic                    w_full_q, w_full_d;
  logic [31:0]             w_data_q, w_data_d;
  logic [3:0]              w_strb_q, w_strb_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [NUM_REGS*32-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]     wr_strobe_q, wr_strobe_d;

  logic aw_hs, w_hs, idx_ok;

  // Byte-offset bits of the address carry no information for word registers.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^AWADDR[1:0];

  // Ready is forced low during reset so nothing is accepted while ARESETN is asserted.
  assign AWREADY = ARESETN && (state_q == IDLE) && !aw_full_q;
  assign WREADY  = ARESETN && (state_q == IDLE) && !w_full_q;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign idx_ok  = int'(aw_addr_q) < NUM_REGS;

  always_comb begin
    state_d     = state_q;
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bresp_d     = bresp_q;
    // Self-clearing bits drop back to zero on every cycle they are not being written.
    regs_d      = regs_q & ~PULSE_MASK;
    wr_strobe_d = '0;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_full_d = 1'b1;
          aw_addr_d = AWADDR[ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_full_d = 1'b1;
          w_data_d = WDATA;
          w_strb_d = WSTRB;
        end
        if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) state_d = WRITE;
      end
      WRITE: begin
        if (idx_ok) begin
          bresp_d = RESP_OKAY;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(aw_addr_q) == i) begin
              wr_strobe_d[i] = 1'b1;
              for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) regs_d[32*i+8*b +: 8] = w_data_q[8*b +: 8];
              end
            end
          end
        end else begin
          bresp_d = RESP_SLVERR;
        end
        state_d = RESP;
      end
      RESP: begin
        if (BREADY) begin
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      aw_full_q   <= 1'b0;
      aw_addr_q   <= '0;
      w_full_q    <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      bresp_q     <= RESP_OKAY;
      regs_q      <= RESET_VALUE;
      wr_strobe_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_full_q   <= aw_full_d;
      aw_addr_q   <= aw_addr_d;
      w_full_q    <= w_full_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bresp_q     <= bresp_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
    end
  end

  assign BVALID    = (state_q == RESP);
  assign BRESP     = bresp_q;
  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_adc_axil_regfile_write.sv
// Bench for adc_axil_regfile_write: directed scenarios plus randomized writes
// checked against an array-based register model.
module tb_adc_axil_regfile_write;

  localparam logic [255:0] RV = {32'h1234_5678, 96'h0, 32'hA5A5_0000, 96'h0};
  localparam logic [255:0] PM = {64'h0, 32'hFF00_0000, 128'h0, 32'h0000_0001};

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [7:0]   AWADDR = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [255:0] regs_out;
  logic [7:0]   wr_strobe;

  adc_axil_regfile_write #(
    .NUM_REGS(8), .ADDR_WIDTH(8), .RESET_VALUE(RV), .PULSE_MASK(PM)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .regs_out(regs_out), .wr_strobe(wr_strobe)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [8];

  // Observations from the most recent transaction
  logic [1:0]   o_resp;
  logic [255:0] o_first, o_second;
  logic [7:0]   o_strobe;
  int           o_strobe_cycles, o_lat, o_viol;
  logic         o_bvalid_second, o_post_bvalid, o_timeout;

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d, logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction

  function automatic logic [255:0] model_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  function automatic logic [31:0] pm_word(int i);
    return PM[32*i +: 32];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = RV[32*i +: 32];
  endtask

  // Drives one AXI write with per-channel start delays and BREADY delay after BVALID.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int c;
    bit aw_done, w_done, seen, got_b, sec;
    c = 0; aw_done = 0; w_done = 0; seen = 0; got_b = 0; sec = 0;
    o_resp = 2'bxx; o_first = 'x; o_second = 'x; o_strobe = 'x;
    o_strobe_cycles = 0; o_lat = -1; o_viol = 0;
    o_bvalid_second = 1'bx; o_post_bvalid = 1'bx;
    while (!got_b && c < 60) begin
      @(negedge ACLK);
      if (BVALID && !seen) begin
        seen = 1; o_lat = c; o_resp = BRESP; o_first = regs_out; o_strobe = wr_strobe;
      end else if (seen && !sec) begin
        sec = 1; o_second = regs_out; o_bvalid_second = BVALID;
      end
      if (wr_strobe != 0) o_strobe_cycles++;
      if (w_done && !aw_done && WREADY) o_viol++;
      if (aw_done && !w_done && AWREADY) o_viol++;
      AWADDR  = addr;
      WDATA   = data;
      WSTRB   = strb;
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      BREADY  = seen && ((c - o_lat) >= b_dly);
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      if (BVALID && BREADY) got_b = 1;
      c++;
    end
    o_timeout = !got_b;
    @(negedge ACLK);
    if (!sec) begin o_second = regs_out; o_bvalid_second = BVALID; end
    o_post_bvalid = BVALID;
    if (wr_strobe != 0) o_strobe_cycles++;
    AWVALID = 0; WVALID = 0; BREADY = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge ACLK);
    n_checks++; if (AWREADY !== 1'b0 || WREADY !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: awready=%b wready=%b expected 0 0", AWREADY, WREADY); end
    n_checks++; if (BVALID !== 1'b0 || BRESP !== 2'b00) begin n_fail++;
      $display("FAIL reset_b: bvalid=%b bresp=%b expected 0 00", BVALID, BRESP); end
    n_checks++; if (regs_out !== RV) begin n_fail++;
      $display("FAIL reset_regs: got %h expected %h", regs_out, RV); end
    n_checks++; if (wr_strobe !== 8'h00) begin n_fail++;
      $display("FAIL reset_strobe: got %h expected 00", wr_strobe); end
    ARESETN = 1'b1;
    @(negedge ACLK);
    n_checks++; if (AWREADY !== 1'b1 || WREADY !== 1'b1) begin n_fail++;
      $display("FAIL idle_ready: awready=%b wready=%b expected 1 1", AWREADY, WREADY); end
  endtask

  task automatic test_simultaneous();
    logic [255:0] exp;
    model[1] = merge(model[1], 32'hDEADBEEF, 4'hF);
    exp = model_vec();
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    n_checks++; if (o_timeout || o_lat !== 2) begin n_fail++;
      $display("FAIL simul_latency: got %0d (timeout=%b) expected 2", o_lat, o_timeout); end
    n_checks++; if (o_first !== exp) begin n_fail++;
      $display("FAIL simul_regs: got %h expected %h", o_first, exp); end
    n_checks++; if (o_strobe !== 8'h02 || o_strobe_cycles !== 1) begin n_fail++;
      $display("FAIL simul_strobe: got %h x%0d expected 02 x1", o_strobe, o_strobe_cycles); end
    n_checks++; if (o_resp !== 2'b00 || o_bvalid_second !== 1'b0) begin n_fail++;
      $display("FAIL simul_b: bresp=%b bvalid_next=%b expected 00 0", o_resp, o_bvalid_second); end
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [255:0] exp;
    d = $urandom;
    model[0] = merge(model[0], d, 4'hF);
    exp = model_vec();
    model[0] = model[0] & ~pm_word(0);
    do_write(8'h00, d, 4'hF, 3, 0, 0);
    n_checks++; if (o_timeout || o_lat !== 5) begin n_fail++;
      $display("FAIL w_first_latency: got %0d (timeout=%b) expected 5", o_lat, o_timeout); end
    n_checks++; if (o_viol !== 0) begin n_fail++;
      $display("FAIL w_first_ready: %0d cycles ready while buffer full, expected 0", o_viol); end
    n_checks++; if (o_first !== exp || o_strobe_cycles !== 1) begin n_fail++;
      $display("FAIL w_first_regs: got %h x%0d expected %h x1", o_first, o_strobe_cycles, exp); end
  endtask

  task automatic test_byte_lanes();
    do_write(8'h08, 32'h11223344, 4'hF, 1, 0, 1);
    model[2] = 32'h11223344;
    do_write(8'h08, 32'hAABBCCDD, 4'b0101, 0, 2, 0);
    model[2] = merge(model[2], 32'hAABBCCDD, 4'b0101);
    n_checks++; if (o_first[95:64] !== 32'h11BB33DD) begin n_fail++;
      $display("FAIL byte_lanes: got %h expected 11bb33dd", o_first[95:64]); end
    n_checks++; if (o_second !== model_vec()) begin n_fail++;
      $display("FAIL byte_lanes_vec: got %h expected %h", o_second, model_vec()); end
  endtask

  task automatic test_out_of_range();
    logic [255:0] exp;
    exp = model_vec();
    do_write(8'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    n_checks++; if (o_resp !== 2'b10) begin n_fail++;
      $display("FAIL oor_resp: got %b expected 10", o_resp); end
    n_checks++; if (o_first !== exp || o_second !== exp) begin n_fail++;
      $display("FAIL oor_regs: got %h expected %h", o_first, exp); end
    n_checks++; if (o_strobe !== 8'h00 || o_strobe_cycles !== 0) begin n_fail++;
      $display("FAIL oor_strobe: got %h x%0d expected 00 x0", o_strobe, o_strobe_cycles); end
    do_write(8'hFC, 32'h0, 4'hF, 2, 1, 0);
    n_checks++; if (o_resp !== 2'b10 || o_first !== exp) begin n_fail++;
      $display("FAIL oor_top: bresp=%b expected 10", o_resp); end
  endtask

  task automatic test_boundaries();
    logic [255:0] exp;
    exp = model_vec();
    do_write(8'h1F, 32'hCAFE_F00D, 4'h0, 0, 0, 0);
    n_checks++; if (o_resp !== 2'b00 || o_strobe !== 8'h80 || o_strobe_cycles !== 1) begin n_fail++;
      $display("FAIL strb0: bresp=%b strobe=%h x%0d expected 00 80 x1", o_resp, o_strobe, o_strobe_cycles); end
    n_checks++; if (o_first !== exp) begin n_fail++;
      $display("FAIL strb0_regs: got %h expected %h", o_first, exp); end
  endtask

  task automatic test_pulse();
    model[0] = merge(model[0], 32'h1, 4'hF);
    do_write(8'h00, 32'h1, 4'hF, 0, 0, 5);
    n_checks++; if (o_first[0] !== 1'b1) begin n_fail++;
      $display("FAIL pulse_high: bit0=%b expected 1", o_first[0]); end
    n_checks++; if (o_second[0] !== 1'b0 || o_bvalid_second !== 1'b1) begin n_fail++;
      $display("FAIL pulse_clear: bit0=%b bvalid=%b expected 0 1", o_second[0], o_bvalid_second); end
    n_checks++; if (o_timeout || o_lat !== 2 || o_strobe_cycles !== 1 || o_post_bvalid !== 1'b0) begin n_fail++;
      $display("FAIL pulse_b: lat=%0d strobes=%0d post_bvalid=%b expected 2 1 0",
               o_lat, o_strobe_cycles, o_post_bvalid); end
    model[0] = model[0] & ~pm_word(0);
  endtask

  task automatic test_reset_mid_resp();
    logic [31:0] d;
    d = $urandom;
    @(negedge ACLK);
    AWADDR = 8'h0C; WDATA = d; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
    @(negedge ACLK);
    AWVALID = 0; WVALID = 0;
    for (int k = 0; k < 10 && !BVALID; k++) @(negedge ACLK);
    n_checks++; if (BVALID !== 1'b1 || regs_out[127:96] !== d) begin n_fail++;
      $display("FAIL mid_resp_reach: bvalid=%b reg3=%h expected 1 %h", BVALID, regs_out[127:96], d); end
    #2 ARESETN = 1'b0;
    #1;
    n_checks++; if (BVALID !== 1'b0 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin n_fail++;
      $display("FAIL mid_reset_ctrl: bvalid=%b awready=%b wready=%b expected 0 0 0", BVALID, AWREADY, WREADY); end
    n_checks++; if (regs_out !== RV || wr_strobe !== 8'h00) begin n_fail++;
      $display("FAIL mid_reset_regs: got %h expected %h", regs_out, RV); end
    model_reset();
    @(negedge ACLK);
    ARESETN = 1'b1;
    d = $urandom;
    model[3] = merge(model[3], d, 4'b0011);
    do_write(8'h0C, d, 4'b0011, 0, 0, 0);
    n_checks++; if (o_timeout || o_lat !== 2 || o_resp !== 2'b00 || o_first !== model_vec()) begin n_fail++;
      $display("FAIL post_reset_write: lat=%0d bresp=%b regs=%h expected 2 00 %h",
               o_lat, o_resp, o_first, model_vec()); end
  endtask

  task automatic test_random();
    logic [7:0] addr;
    logic [31:0] d;
    logic [3:0] s;
    int aw, w, b, idx, exp_lat;
    bit ok;
    logic [255:0] exp_first;
    for (int n = 0; n < 40; n++) begin
      addr = 8'($urandom_range(0, 43));
      d = $urandom; s = 4'($urandom); aw = $urandom_range(0, 3);
      w = $urandom_range(0, 3); b = $urandom_range(0, 2);
      idx = int'(addr[7:2]);
      ok = idx < 8;
      exp_lat = ((aw > w) ? aw : w) + 2;
      if (ok) model[idx] = merge(model[idx], d, s);
      exp_first = model_vec();
      if (ok) model[idx] = model[idx] & ~pm_word(idx);
      do_write(addr, d, s, aw, w, b);
      n_checks++; if (o_timeout || o_lat !== exp_lat) begin n_fail++;
        $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, o_lat, exp_lat); end
      n_checks++; if (o_resp !== (ok ? 2'b00 : 2'b10)) begin n_fail++;
        $display("FAIL rand_resp[%0d]: got %b expected %b", n, o_resp, ok ? 2'b00 : 2'b10); end
      n_checks++; if (o_first !== exp_first) begin n_fail++;
        $display("FAIL rand_first[%0d]: got %h expected %h", n, o_first, exp_first); end
      n_checks++; if (o_second !== model_vec()) begin n_fail++;
        $display("FAIL rand_second[%0d]: got %h expected %h", n, o_second, model_vec()); end
      n_checks++; if (o_strobe !== (ok ? 8'(1 << idx) : 8'h00) || o_strobe_cycles !== (ok ? 1 : 0)) begin
        n_fail++; $display("FAIL rand_strobe[%0d]: got %h x%0d idx=%0d", n, o_strobe, o_strobe_cycles, idx); end
      n_checks++; if (o_bvalid_second !== (b > 0) || o_post_bvalid !== 1'b0 || o_viol !== 0) begin n_fail++;
        $display("FAIL rand_handshake[%0d]: bvalid_next=%b post=%b viol=%0d expected %b 0 0",
                 n, o_bvalid_second, o_post_bvalid, o_viol, b > 0); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_simultaneous();
    test_w_before_aw();
    test_byte_lanes();
    test_out_of_range();
    test_boundaries();
    test_pulse();
    test_reset_mid_resp();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
